// File: rtl/cntr_mon_pkg.sv
// rtl/cntr_mon_pkg.sv - shared types and defaults for the counter stream monitor
package cntr_mon_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 16;
  // Sample fields are carried at a fixed maximum width; narrower WIDTH values zero-extend.
  localparam int MAX_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEEK,
    ST_TRACK
  } state_t;

  typedef struct packed {
    logic             ena;
    logic [MAX_W-1:0] limit;
    logic [MAX_W-1:0] q;
    logic             done;
  } sample_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with synchronous clear
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;
  logic [W-1:0] w_base;

  // A clear in the same cycle as an increment still counts the new event.
  assign w_base = i_clr ? '0 : r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr || i_inc) begin
      r_cnt <= (i_inc && (w_base != '1)) ? w_base + W'(1) : w_base;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/cntr_stream_monitor.sv
// rtl/cntr_stream_monitor.sv - passive checker for an up-counter's q/done stream
module cntr_stream_monitor
  import cntr_mon_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [WIDTH-1:0] limit,
  input  logic [WIDTH-1:0] q,
  input  logic             done,
  input  logic             clr,
  output logic             locked,
  output logic             err,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] wrap_cnt,
  output logic [WIDTH-1:0] meas_limit,
  output logic             meas_valid
);

  sample_t          r_cur;
  logic             r_prv_ena;
  logic [MAX_W-1:0] r_prv_limit;
  logic [MAX_W-1:0] r_prv_q;
  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_locked;
  logic             r_err;
  logic             r_err_pulse;
  logic [WIDTH-1:0] r_meas_limit;
  logic             r_meas_valid;
  logic [MAX_W-1:0] w_exp_q;
  logic             w_exp_done;
  logic             w_check;
  logic             w_mismatch;
  logic             w_wrap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cur       <= '0;
      r_prv_ena   <= 1'b0;
      r_prv_limit <= '0;
      r_prv_q     <= '0;
    end else begin
      r_cur       <= '{ena: ena, limit: MAX_W'(limit), q: MAX_W'(q), done: done};
      r_prv_ena   <= r_cur.ena;
      r_prv_limit <= r_cur.limit;
      r_prv_q     <= r_cur.q;
    end
  end

  // Unsigned rule with no modular wrap: q at or above limit must return to zero.
  always_comb begin
    w_exp_q    = '0;
    w_exp_done = 1'b1;
    if (r_prv_q < r_prv_limit) begin
      w_exp_q    = r_prv_q + MAX_W'(1);
      w_exp_done = 1'b0;
    end
  end

  assign w_check    = (r_state == ST_TRACK) && r_cur.ena && r_prv_ena;
  assign w_mismatch = w_check && ((r_cur.q != w_exp_q) || (r_cur.done != w_exp_done));
  assign w_wrap     = w_check && !w_mismatch && r_cur.done;

  always_comb begin
    w_state_nxt = r_state;
    if (!r_cur.ena) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  w_state_nxt = ST_SEEK;
        ST_SEEK:  if (r_cur.q == '0) w_state_nxt = ST_TRACK;
        ST_TRACK: if (w_mismatch) w_state_nxt = ST_SEEK;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_locked     <= 1'b0;
      r_err        <= 1'b0;
      r_err_pulse  <= 1'b0;
      r_meas_limit <= '0;
      r_meas_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_err_pulse  <= w_mismatch;
      r_meas_valid <= w_wrap;
      if (!r_cur.ena || w_mismatch) r_locked <= 1'b0;
      else if (w_wrap)              r_locked <= 1'b1;
      if (w_mismatch)               r_err <= 1'b1;
      else if (clr)                 r_err <= 1'b0;
      if (w_wrap)                   r_meas_limit <= WIDTH'(r_prv_q);
    end
  end

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_clr (clr),
    .i_inc (w_mismatch),
    .o_cnt (err_cnt)
  );

  sat_counter #(.W(CNT_W)) u_wrap_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_clr (clr),
    .i_inc (w_wrap),
    .o_cnt (wrap_cnt)
  );

  assign locked     = r_locked;
  assign err        = r_err;
  assign err_pulse  = r_err_pulse;
  assign meas_limit = r_meas_limit;
  assign meas_valid = r_meas_valid;

endmodule

// File: doc/cntr_stream_monitor.md
# cntr_stream_monitor

Receive-side checker for the up-counter's output stream. It samples the counter's count value, done pulse, enable and limit, and checks every cycle against the counter's transition rule. It reports lock, sticky and pulsed errors, the wrap count and the measured terminal count. It sits beside the counter on the same clock, either in the top-level test harness or as an on-chip self-check, and observes only; it never drives the counter.

## Interface
- `WIDTH`, 8, width of count value and limit
- `CNT_W`, 16, width of wrap and error counters
- `clk` in 1: single clock; all logic rising-edge
- `rst` in 1: asynchronous, active-high reset
- `ena` in 1: counter enable, aligned with `q`
- `limit` in WIDTH: terminal count, aligned with `q` (the counter's internally synchronized copy)
- `q` in WIDTH: observed count value
- `done` in 1: observed wrap flag
- `clr` in 1: synchronous clear of `err`, `err_cnt`, `wrap_cnt`
- `locked` out 1: stream verified through at least one full wrap
- `err` out 1: sticky mismatch flag
- `err_pulse` out 1: one-cycle pulse per mismatch
- `err_cnt` out CNT_W: saturating mismatch count
- `wrap_cnt` out CNT_W: saturating count of verified wraps
- `meas_limit` out WIDTH: last `q` observed before the most recent wrap
- `meas_valid` out 1: one-cycle pulse when `meas_limit` updates

## Operation
- Input stage: `ena`, `limit`, `q`, `done` registered each cycle into the current sample `cur`. The previous `cur` is held as `prv`.
- Expected rule, evaluated on `prv`:
  - if `prv.q < prv.limit`: expect `cur.q = prv.q+1` and `cur.done = 0`
  - else: expect `cur.q = 0` and `cur.done = 1`
  - Compare is unsigned, WIDTH bits; no modular wrap is expected.
- States:
  - IDLE: entered on reset or when `cur.ena = 0`. No checking. `locked = 0`.
  - SEEK: entered from IDLE when `cur.ena = 1`. Waits for a sample with `cur.q = 0`, then moves to TRACK. No checking while in SEEK.
  - TRACK: checks every sample while `cur.ena = 1` and `prv.ena = 1`.
    - Mismatch: `err_pulse` fires, `err` is set, `err_cnt` increments, `locked` clears, and the block returns to SEEK.
    - Match with `cur.done = 1`: `wrap_cnt` increments, `meas_limit <= prv.q`, `meas_valid` pulses, `locked` sets.
  - Any state goes to IDLE when `cur.ena = 0`. This takes priority over all other transitions.
- `limit = 0`: the expected stream is `q = 0, done = 1` on every sample, so a wrap is counted every cycle and `meas_limit = 0`.
- A limit change mid-count needs no special case: the rule uses `prv.limit`. If the new limit is below `q`, the stream must wrap to 0 with `done = 1` on the next sample.
- Counters saturate at all-ones and do not roll over.
- `clr` zeroes `err`, `err_cnt` and `wrap_cnt`. It does not change state, `locked` or `meas_limit`.
- `clr` coincident with a mismatch: the error wins, giving `err = 1` and `err_cnt = 1`.
- `clr` coincident with a wrap: `wrap_cnt = 1`.

## Timing
- Reset values: `locked = 0`, `err = 0`, `err_pulse = 0`, `err_cnt = 0`, `wrap_cnt = 0`, `meas_limit = 0`, `meas_valid = 0`; state IDLE; `cur` and `prv` zero.
- Latency: a sample presented in cycle N is captured at the end of N. The resulting outputs are registered and visible in cycle N+2.
- `err_pulse` and `meas_valid` are exactly one cycle wide per event. Back-to-back events produce back-to-back pulses.
- `rst` asserted mid-operation clears everything immediately and asynchronously.
- After `rst` deasserts, the first TRACK check can occur no earlier than two samples after `ena = 1` is observed.

## Structure
- Package `cntr_mon_pkg`: state enum (IDLE, SEEK, TRACK), default WIDTH and CNT_W constants, and a sample struct (`ena`, `limit`, `q`, `done`).
- Sub-module `sat_counter`: parameterized saturating counter with `inc` and `clr` inputs, and increment taking precedence as `clr` then +1. It is instantiated twice, for `wrap_cnt` and `err_cnt`.
- The top module contains the input and previous-sample registers, the expected-value compare, the FSM, and the `meas_limit` register.

## Test plan
- Limit 3, `ena` high, clean stream 0,1,2,3,0(done)… → `locked = 1` after the first wrap. `wrap_cnt` reaches 4 after 4 wraps, `meas_limit = 3`, `err = 0`.
- Limit 3, inject `q = 2` where 3 is expected → single `err_pulse` at N+2, `err = 1`, `err_cnt = 1`, `locked = 0`. The block relocks after the next clean wrap.
- Limit 0, `ena` high → `wrap_cnt` increments every cycle, `meas_limit = 0`, no errors. With CNT_W = 4, `wrap_cnt` saturates at 15.
- Limit changed from 200 to 10 while `q = 50` → next sample `q = 0` with `done = 1` passes. `meas_limit = 50`, no error.
- `ena` dropped mid-count, then raised → IDLE with `locked = 0` and no errors. Counting restarts from 0 with no false error.
- `clr` asserted in the same cycle as a mismatch → `err = 1`, `err_cnt = 1`, `wrap_cnt = 0`.
- `rst` pulsed mid-TRACK → all outputs return to their reset values asynchronously.
